csr_access_sched: RTL and testbench
===================================

CSR_ACCESS_SCHED -- requirements
Module: csr_access_sched

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 core_valid_i / core_ready_o  in/out  1/1  core request handshake.
REQ-005 core_addr_i  in  12  CSR number (csr_num_e encoding).
REQ-006 core_op_i  in  2  00 read, 01 write, 10 set, 11 clear.
REQ-007 core_wdata_i  in  32  write data or bit mask.
REQ-008 core_priv_i  in  2  core privilege (priv_lvl_e).
REQ-009 dbg_valid_i / dbg_ready_o, dbg_addr_i[11:0], dbg_op_i[1:0], dbg_wdata_i[31:0]: debug requester, same meaning; privilege is always PRIV_LVL_M.
REQ-010 debug_mode_i  in  1  core is in debug mode.
REQ-011 csr_addr_o  out  12, csr_re_o  out  1, csr_we_o  out  1, csr_wdata_o  out  32: single-port CSR file access.
REQ-012 csr_rdata_i  in  32, csr_err_i  in  1: valid exactly one cycle after csr_re_o.
REQ-013 rsp_valid_o  out  1, rsp_ready_i  in  1, rsp_src_o  out  1 (0 core, 1 debug), rsp_rdata_o  out  32, rsp_illegal_o  out  1.

Function
REQ-014 FSM states IDLE, RD, CAP, WR, RSP; one transaction in flight.
REQ-015 In IDLE, ready is driven high to the granted requester only, in the same cycle; acceptance = valid & ready; addr/op/wdata/source latched on acceptance.
REQ-016 Arbitration is round-robin: when both valid, grant goes to the source not granted last; last-grant pointer resets to "core", so debug wins the first contest.
REQ-017 Legality is checked at acceptance: illegal if addr[9:8] > requester privilege; illegal if addr[11:10]==2'b11 and op != read; illegal if addr in 0x7B0..0x7B3 from core while debug_mode_i==0.
REQ-018 Illegal request: IDLE -> RSP next cycle, rsp_illegal_o=1, rsp_rdata_o=0, no csr_re_o/csr_we_o.
REQ-019 Legal request: IDLE -> RD; RD drives csr_re_o=1, csr_addr_o=latched addr for exactly one cycle; RD -> CAP.
REQ-020 CAP samples csr_rdata_i (old value) and csr_err_i; err -> RSP with illegal=1, rdata=0, no write.
REQ-021 New value: write = wdata; set = old | wdata; clear = old & ~wdata.
REQ-022 Write skipped (CAP -> RSP) for read, and for set/clear with wdata == 0; otherwise CAP -> WR.
REQ-023 WR drives csr_we_o=1, csr_addr_o, csr_wdata_o=new value for exactly one cycle; WR -> RSP.
REQ-024 RSP holds rsp_valid_o=1 with stable rsp_src_o/rsp_rdata_o (old value)/rsp_illegal_o until rsp_ready_i=1; then -> IDLE.
REQ-025 Back-to-back: new request can be accepted in the cycle after RSP handshake (IDLE); no acceptance in the RSP handshake cycle.
REQ-026 Latency, legal read with rsp_ready_i=1: accept cycle 0, csr_re_o cycle 1, rsp_valid_o cycle 3; with write: csr_we_o cycle 3, rsp_valid_o cycle 4.
REQ-027 csr_re_o and csr_we_o are never high in the same cycle; both low outside RD/WR.
REQ-028 debug_mode_i changing after acceptance does not alter the latched legality result.

Reset
REQ-029 rst_ni=0 at a rising edge forces IDLE, including mid-transaction; any in-flight write not yet in WR is dropped.
REQ-030 Reset values: core_ready_o, dbg_ready_o, csr_re_o, csr_we_o, rsp_valid_o, rsp_src_o, rsp_illegal_o = 0; csr_addr_o, csr_wdata_o, rsp_rdata_o = 0; last-grant pointer = core.

Verification
REQ-031 Core read MISA (0x301, priv M, op 00), csr_rdata_i=0x40101104 -> one csr_re_o, no csr_we_o, rsp_rdata_o=0x40101104, illegal=0, rsp at cycle 3.
REQ-032 Core set MSTATUS (0x300, op 10, wdata 0x8), old 0x1880 -> csr_we_o with wdata 0x1888, rsp_rdata_o=0x1880; repeat with wdata 0 -> no csr_we_o.
REQ-033 Core read DCSR (0x7B0) with debug_mode_i=0 -> rsp_illegal_o=1 at cycle 1 later RSP, rdata 0, no CSR port activity; same from debug requester -> legal.
REQ-034 Core write MHARTID (0xF14, op 01) -> illegal, no write; core priv U reading MSTATUS -> illegal.
REQ-035 Core and debug valid together three times with rsp_ready_i=1 -> grants debug, core, debug; each loser's ready low until granted, inputs held.
REQ-036 rst_ni low during WR of pending clear on MIE, and rsp_ready_i low holding RSP for 5 cycles -> reset returns all outputs to REQ-030 values next edge; held RSP outputs stable for all 5 cycles.

Source files
------------

// File: rtl/csr_access_sched.sv
// CSR access scheduler: arbitrates core and debug requests onto a single-port
// CSR file. It checks legality, runs read / read-modify-write sequences and
// returns one response per request.
//
// Handshake rules (core, debug and response channels): a transfer happens in
// the cycle where valid and ready are both high at the rising edge. A
// requester holds valid and its payload stable until it is accepted. The
// response side holds rsp_valid_o and its payload stable until rsp_ready_i
// is high.
module csr_access_sched (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_valid_i,
  output logic        core_ready_o,
  input  logic [11:0] core_addr_i,
  input  logic [1:0]  core_op_i,
  input  logic [31:0] core_wdata_i,
  input  logic [1:0]  core_priv_i,
  input  logic        dbg_valid_i,
  output logic        dbg_ready_o,
  input  logic [11:0] dbg_addr_i,
  input  logic [1:0]  dbg_op_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic        debug_mode_i,
  output logic [11:0] csr_addr_o,
  output logic        csr_re_o,
  output logic        csr_we_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  input  logic        csr_err_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_src_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  output logic [2:0]  state_o
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] PRIV_M   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_e;

  state_e      state_q;
  logic        last_dbg_q;   // 1 when the debug requester won the last grant
  logic [1:0]  op_q;
  logic [31:0] wdata_q;

  logic        grant_dbg;
  logic        grant_core;
  logic        accept;
  logic [11:0] sel_addr;
  logic [1:0]  sel_op;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_priv;
  logic        illegal;
  logic [31:0] new_val;
  logic        skip_wr;

  assign state_o = state_q;

  // Round-robin grant, ready gating and legality of the granted request
  always_comb begin
    grant_dbg    = dbg_valid_i & (~core_valid_i | ~last_dbg_q);
    grant_core   = core_valid_i & ~grant_dbg;
    core_ready_o = rst_ni & (state_q == S_IDLE) & grant_core;
    dbg_ready_o  = rst_ni & (state_q == S_IDLE) & grant_dbg;
    accept       = (state_q == S_IDLE) & (grant_core | grant_dbg);
    sel_addr     = grant_dbg ? dbg_addr_i  : core_addr_i;
    sel_op       = grant_dbg ? dbg_op_i    : core_op_i;
    sel_wdata    = grant_dbg ? dbg_wdata_i : core_wdata_i;
    sel_priv     = grant_dbg ? PRIV_M      : core_priv_i;
    illegal      = 1'b0;
    if (sel_addr[9:8] > sel_priv) illegal = 1'b1;
    if ((sel_addr[11:10] == 2'b11) && (sel_op != OP_READ)) illegal = 1'b1;
    // 0x7B0..0x7B3 are debug-only CSRs; the core may reach them only in debug mode
    if (!grant_dbg && (sel_addr[11:2] == 10'h1EC) && !debug_mode_i) illegal = 1'b1;
  end

  // Read-modify-write value and write-skip decision from the captured old value
  always_comb begin
    case (op_q)
      OP_WRITE: new_val = wdata_q;
      OP_SET:   new_val = csr_rdata_i | wdata_q;
      OP_READ:  new_val = csr_rdata_i;
      default:  new_val = csr_rdata_i & ~wdata_q;
    endcase
    skip_wr = (op_q == OP_READ) | ((op_q != OP_WRITE) & (wdata_q == 32'd0));
  end

  // Transaction FSM with registered CSR-port and response outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      last_dbg_q    <= 1'b0;
      op_q          <= OP_READ;
      wdata_q       <= 32'd0;
      csr_addr_o    <= 12'd0;
      csr_re_o      <= 1'b0;
      csr_we_o      <= 1'b0;
      csr_wdata_o   <= 32'd0;
      rsp_valid_o   <= 1'b0;
      rsp_src_o     <= 1'b0;
      rsp_rdata_o   <= 32'd0;
      rsp_illegal_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            last_dbg_q <= grant_dbg;
            rsp_src_o  <= grant_dbg;
            op_q       <= sel_op;
            wdata_q    <= sel_wdata;
            if (illegal) begin
              state_q       <= S_RSP;
              rsp_valid_o   <= 1'b1;
              rsp_illegal_o <= 1'b1;
              rsp_rdata_o   <= 32'd0;
            end else begin
              state_q    <= S_RD;
              csr_re_o   <= 1'b1;
              csr_addr_o <= sel_addr;
            end
          end
        end
        S_RD: begin
          csr_re_o <= 1'b0;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          if (csr_err_i) begin
            state_q       <= S_RSP;
            rsp_valid_o   <= 1'b1;
            rsp_illegal_o <= 1'b1;
            rsp_rdata_o   <= 32'd0;
          end else if (skip_wr) begin
            state_q       <= S_RSP;
            rsp_valid_o   <= 1'b1;
            rsp_illegal_o <= 1'b0;
            rsp_rdata_o   <= csr_rdata_i;
          end else begin
            state_q       <= S_WR;
            csr_we_o      <= 1'b1;
            csr_wdata_o   <= new_val;
            rsp_illegal_o <= 1'b0;
            rsp_rdata_o   <= csr_rdata_i;
          end
        end
        S_WR: begin
          csr_we_o    <= 1'b0;
          rsp_valid_o <= 1'b1;
          state_q     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_sched.sv
// Bench for csr_access_sched: a CSR file responder, a reference model of the
// request rules and a linear sequence of directed and random steps.
module tb_csr_access_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_valid, core_ready;
  logic [11:0] core_addr;
  logic [1:0]  core_op, core_priv;
  logic [31:0] core_wdata;
  logic        dbg_valid, dbg_ready;
  logic [11:0] dbg_addr;
  logic [1:0]  dbg_op;
  logic [31:0] dbg_wdata;
  logic        debug_mode;
  logic [11:0] csr_addr;
  logic        csr_re, csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_err;
  logic        rsp_valid, rsp_ready, rsp_src, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] exp_q[$];
  int          re_cnt  = 0;
  int          we_cnt  = 0;
  int          both_hi = 0;
  logic [31:0] last_wd;
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;
  logic [11:0] err_addr;
  logic [11:0] pool [10];

  csr_access_sched dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_valid_i(core_valid), .core_ready_o(core_ready), .core_addr_i(core_addr),
    .core_op_i(core_op), .core_wdata_i(core_wdata), .core_priv_i(core_priv),
    .dbg_valid_i(dbg_valid), .dbg_ready_o(dbg_ready), .dbg_addr_i(dbg_addr),
    .dbg_op_i(dbg_op), .dbg_wdata_i(dbg_wdata), .debug_mode_i(debug_mode),
    .csr_addr_o(csr_addr), .csr_re_o(csr_re), .csr_we_o(csr_we), .csr_wdata_o(csr_wdata),
    .csr_rdata_i(csr_rdata), .csr_err_i(csr_err),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_src_o(rsp_src),
    .rsp_rdata_o(rsp_rdata), .rsp_illegal_o(rsp_illegal), .state_o(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CSR file model: read data one cycle after csr_re, garbage otherwise
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (csr_re && csr_we) both_hi <= both_hi + 1;
    if (csr_re) begin
      re_cnt    <= re_cnt + 1;
      csr_rdata <= mem[csr_addr];
      csr_err   <= (csr_addr == err_addr);
    end else begin
      csr_rdata <= $urandom;
      csr_err   <= 1'b0;
    end
    if (csr_we) begin
      we_cnt        <= we_cnt + 1;
      mem[csr_addr] <= csr_wdata;
      last_wd       <= csr_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_core_ready", 32'(core_ready), 0);
    chk("rst_dbg_ready", 32'(dbg_ready), 0);
    chk("rst_csr_re", 32'(csr_re), 0);
    chk("rst_csr_we", 32'(csr_we), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_src", 32'(rsp_src), 0);
    chk("rst_rsp_illegal", 32'(rsp_illegal), 0);
    chk("rst_csr_addr", 32'(csr_addr), 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
  endtask

  // One request end to end; model computes legality, response and write effect
  task automatic run_txn(input bit src, input logic [11:0] addr, input logic [1:0] op,
                         input logic [31:0] wd, input logic [1:0] priv,
                         input bit flip_dm, input int hold);
    logic [1:0]  eff;
    bit          ill, err, do_wr;
    logic [31:0] old, newv, exp_rd;
    int          re0, we0, lat, n;
    eff = src ? 2'b11 : priv;
    ill = (addr[9:8] > eff) || (addr[11:10] == 2'b11 && op != 2'b00) ||
          (!src && addr >= 12'h7B0 && addr <= 12'h7B3 && !debug_mode);
    old = ref_mem[addr];
    err = !ill && (addr == err_addr);
    case (op)
      2'b01:   newv = wd;
      2'b10:   newv = old | wd;
      2'b11:   newv = old & ~wd;
      default: newv = old;
    endcase
    do_wr = !ill && !err && (op == 2'b01 || (op != 2'b00 && wd != 0));
    exp_q.push_back((ill || err) ? 32'd0 : old);
    re0 = re_cnt; we0 = we_cnt;
    @(negedge clk);
    if (src) begin
      dbg_valid = 1'b1; dbg_addr = addr; dbg_op = op; dbg_wdata = wd;
    end else begin
      core_valid = 1'b1; core_addr = addr; core_op = op; core_wdata = wd; core_priv = priv;
    end
    if (hold > 0) rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!(src ? dbg_ready : core_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_ready", 32'(src ? dbg_ready : core_ready), 1);
    @(posedge clk);
    @(negedge clk);
    core_valid = 1'b0; dbg_valid = 1'b0;
    core_addr = 12'($urandom); dbg_addr = 12'($urandom);
    core_wdata = $urandom; dbg_wdata = $urandom;
    if (flip_dm) debug_mode = !debug_mode;
    chk("re_in_cycle1", 32'(csr_re), 32'(!ill));
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    chk("rsp_latency", 32'(lat), ill ? 1 : (do_wr ? 4 : 3));
    exp_rd = exp_q.pop_front();
    chk("rsp_src", 32'(rsp_src), 32'(src));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_illegal", 32'(rsp_illegal), 32'(ill || err));
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_src", 32'(rsp_src), 32'(src));
      chk("hold_illegal", 32'(rsp_illegal), 32'(ill || err));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_released", 32'(rsp_valid), 0);
    if (do_wr) ref_mem[addr] = newv;
    chk("re_count", 32'(re_cnt - re0), ill ? 1'b0 : 1'b1);
    chk("we_count", 32'(we_cnt - we0), 32'(do_wr));
    chk("csr_contents", mem[addr], ref_mem[addr]);
    if (do_wr) chk("write_value", last_wd, newv);
  endtask

  initial begin
    int n;
    bit exp_dbg;
    logic [11:0] a;
    rst_n = 1'b0;
    core_valid = 1'b0; core_addr = 12'd0; core_op = 2'd0; core_wdata = 32'd0; core_priv = 2'd3;
    dbg_valid = 1'b0; dbg_addr = 12'd0; dbg_op = 2'd0; dbg_wdata = 32'd0;
    debug_mode = 1'b0; rsp_ready = 1'b1; err_addr = 12'hFFF;
    pool[0] = 12'h300; pool[1] = 12'h301; pool[2] = 12'h304; pool[3] = 12'h341;
    pool[4] = 12'h7B0; pool[5] = 12'h7B2; pool[6] = 12'hF14; pool[7] = 12'h100;
    pool[8] = 12'h180; pool[9] = 12'hC00;

    // Reset values
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) preload(pool[i], $urandom);

    // Read MISA, set MSTATUS with and without mask
    preload(12'h301, 32'h40101104);
    run_txn(1'b0, 12'h301, 2'b00, 32'd0, 2'b11, 1'b0, 0);
    preload(12'h300, 32'h00001880);
    run_txn(1'b0, 12'h300, 2'b10, 32'h8, 2'b11, 1'b0, 0);
    run_txn(1'b0, 12'h300, 2'b10, 32'h0, 2'b11, 1'b0, 0);

    // Debug-only CSRs, read-only and privilege violations
    debug_mode = 1'b0;
    run_txn(1'b0, 12'h7B0, 2'b00, 32'd0, 2'b11, 1'b0, 0);
    run_txn(1'b1, 12'h7B0, 2'b00, 32'd0, 2'b11, 1'b0, 0);
    run_txn(1'b0, 12'hF14, 2'b01, 32'h1234, 2'b11, 1'b0, 0);
    run_txn(1'b0, 12'h300, 2'b00, 32'd0, 2'b00, 1'b0, 0);

    // Write and clear ops, CSR-file error, legality frozen at acceptance
    run_txn(1'b0, 12'h341, 2'b01, 32'hDEADBEEF, 2'b11, 1'b0, 0);
    run_txn(1'b1, 12'h304, 2'b11, 32'h00FF00FF, 2'b11, 1'b0, 0);
    err_addr = 12'h341;
    run_txn(1'b0, 12'h341, 2'b01, 32'h5, 2'b11, 1'b0, 0);
    err_addr = 12'hFFF;
    debug_mode = 1'b1;
    run_txn(1'b0, 12'h7B1, 2'b01, 32'hA5, 2'b11, 1'b1, 0);
    run_txn(1'b0, 12'h7B2, 2'b00, 32'd0, 2'b11, 1'b1, 0);

    // Response held off for 5 cycles
    run_txn(1'b0, 12'h301, 2'b00, 32'd0, 2'b11, 1'b0, 5);

    // Reset while a clear is in WR: the write lands, outputs go to reset values
    preload(12'h304, 32'h0000FFFF);
    @(negedge clk);
    core_valid = 1'b1; core_addr = 12'h304; core_op = 2'b11; core_wdata = 32'h00000F0F; core_priv = 2'b11;
    #1;
    chk("wrrst_accept", 32'(core_ready), 1);
    @(posedge clk);
    @(negedge clk);
    core_valid = 1'b0;
    n = 0;
    while (!csr_we && n < 10) begin
      @(negedge clk); n++;
    end
    chk("wrrst_we_seen", 32'(csr_we), 1);
    chk("wrrst_wdata", csr_wdata, 32'h0000F0F0);
    ref_mem[12'h304] = 32'h0000F0F0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    chk("wrrst_contents", mem[12'h304], ref_mem[12'h304]);
    rst_n = 1'b1;

    // Reset while in CAP: the pending set is dropped
    preload(12'h300, 32'h0);
    @(negedge clk);
    core_valid = 1'b1; core_addr = 12'h300; core_op = 2'b10; core_wdata = 32'h1;
    #1;
    chk("caprst_accept", 32'(core_ready), 1);
    @(posedge clk);
    @(negedge clk);
    core_valid = 1'b0;
    @(negedge clk);
    n = we_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(negedge clk);
    chk("caprst_no_write", 32'(we_cnt - n), 0);
    chk("caprst_contents", mem[12'h300], 32'h0);
    rst_n = 1'b1;

    // Contention right after reset: debug, core, debug
    @(negedge clk);
    core_valid = 1'b1; core_addr = 12'h301; core_op = 2'b00; core_priv = 2'b11;
    dbg_valid = 1'b1; dbg_addr = 12'h300; dbg_op = 2'b00;
    for (int r = 0; r < 3; r++) begin
      exp_dbg = (r != 1);
      #1;
      n = 0;
      while (!(core_ready || dbg_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk("arb_dbg_ready", 32'(dbg_ready), 32'(exp_dbg));
      chk("arb_core_ready", 32'(core_ready), 32'(!exp_dbg));
      @(posedge clk);
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk); n++;
      end
      chk("arb_rsp_src", 32'(rsp_src), 32'(exp_dbg));
      a = exp_dbg ? 12'h300 : 12'h301;
      chk("arb_rsp_rdata", rsp_rdata, ref_mem[a]);
      chk("arb_loser_wait", 32'(core_ready | dbg_ready), 0);
      @(posedge clk);
      @(negedge clk);
      if (r == 2) begin
        core_valid = 1'b0; dbg_valid = 1'b0;
      end
    end

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      a = pool[$urandom_range(0, 9)];
      debug_mode = 1'($urandom_range(0, 1));
      err_addr = ($urandom_range(0, 7) == 0) ? a : 12'hFFF;
      run_txn(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : 0);
    end
    err_addr = 12'hFFF;

    chk("re_we_never_together", 32'(both_hi), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
